mem_port_arbiter_rr4: RTL and testbench



---
 rtl/mem_port_arbiter_rr4.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter_rr4.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_rr4.sv
// Round-robin owner of one shared memory port for four requesters; grant appears one cycle after an IDLE request.
// Requesters hold req until ack/err; one transaction in flight, watchdog aborts after MAX_WAIT busy cycles.
module mem_port_arbiter_rr4 #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       mem_req_o,
  input  logic       mem_ack_i,
  output logic [3:0] ack_o,
  output logic       err_o,
  output logic [1:0] err_id_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic [1:0] err_id_q, err_id_d;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       timeout;

  // Scan starts just past the last served requester, so last itself is lowest priority.
  always_comb begin
    winner = last_q;
    cand   = last_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // An ack in the final watchdog cycle takes precedence over the abort.
  assign timeout = (state_q == BUSY) && !mem_ack_i && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = 1'b0;
    err_id_d   = err_id_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BUSY;
          sel_d      = winner;
          wait_cnt_d = 8'd0;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          last_d  = sel_q;
        end else if (timeout) begin
          state_d  = IDLE;
          last_d   = sel_q;
          err_d    = 1'b1;
          err_id_d = sel_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      err_id_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
    end
  end

  // Grant and strobe are pure decodes of the state, so they drop the cycle the port frees up.
  always_comb begin
    gnt_o     = 4'b0000;
    mem_req_o = 1'b0;
    ack_o     = 4'b0000;
    if (state_q == BUSY) begin
      gnt_o     = 4'b0001 << sel_q;
      mem_req_o = 1'b1;
      ack_o     = mem_ack_i ? (4'b0001 << sel_q) : 4'b0000;
    end
  end

  assign sel_o    = sel_q;
  assign err_o    = err_q;
  assign err_id_o = err_id_q;

endmodule

// File: tb/tb_mem_port_arbiter_rr4.sv
// Directed bench for mem_port_arbiter_rr4 with a short watchdog (MAX_WAIT=4).
module tb_mem_port_arbiter_rr4;

  logic       clk;
  logic       rst_i;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic [1:0] sel_o;
  logic       mem_req_o;
  logic       mem_ack_i;
  logic [3:0] ack_o;
  logic       err_o;
  logic [1:0] err_id_o;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter_rr4 #(.MAX_WAIT(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .sel_o    (sel_o),
    .mem_req_o(mem_req_o),
    .mem_ack_i(mem_ack_i),
    .ack_o    (ack_o),
    .err_o    (err_o),
    .err_id_o (err_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i     = 1'b1;
    req_i     = 4'b0000;
    mem_ack_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    settle();
    chk("rst_gnt", 8'(gnt_o), 8'h0);
    chk("rst_sel", 8'(sel_o), 8'h0);
    chk("rst_mreq", 8'(mem_req_o), 8'h0);
    chk("rst_ack", 8'(ack_o), 8'h0);
    chk("rst_err", 8'(err_o), 8'h0);
    chk("rst_errid", 8'(err_id_o), 8'h0);

    // single requester, ack on the third busy cycle
    req_i = 4'b0001;
    step();
    settle();
    chk("t1_gnt", 8'(gnt_o), 8'h1);
    chk("t1_sel", 8'(sel_o), 8'h0);
    chk("t1_mreq", 8'(mem_req_o), 8'h1);
    step();
    step();
    mem_ack_i = 1'b1;
    settle();
    chk("t1_ack", 8'(ack_o), 8'h1);
    step();
    req_i     = 4'b0000;
    mem_ack_i = 1'b0;
    settle();
    chk("t1_idle_gnt", 8'(gnt_o), 8'h0);
    chk("t1_idle_mreq", 8'(mem_req_o), 8'h0);

    // all four requesting from last=3, 1-cycle memory
    rst_i = 1'b1;
    step();
    rst_i     = 1'b0;
    req_i     = 4'b1111;
    mem_ack_i = 1'b1;
    for (int g = 0; g < 6; g++) begin
      step();
      settle();
      chk("t2_gnt", 8'(gnt_o), 8'(4'b0001 << (g % 4)));
      chk("t2_ack", 8'(ack_o), 8'(4'b0001 << (g % 4)));
      step();
      settle();
      chk("t2_gap", 8'(gnt_o), 8'h0);
    end

    // last=1, requesters 3 and 0 only
    req_i = 4'b1001;
    step();
    settle();
    chk("t3_sel_a", 8'(sel_o), 8'h3);
    chk("t3_ack_a", 8'(ack_o), 8'h8);
    step();
    settle();
    chk("t3_gap", 8'(gnt_o), 8'h0);
    step();
    settle();
    chk("t3_sel_b", 8'(sel_o), 8'h0);
    chk("t3_gnt_b", 8'(gnt_o), 8'h1);
    step();
    req_i     = 4'b0000;
    mem_ack_i = 1'b0;
    settle();
    chk("t3_idle", 8'(gnt_o), 8'h0);

    // watchdog timeout on requester 2
    req_i = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      step();
      settle();
      chk("t4_mreq", 8'(mem_req_o), 8'h1);
      chk("t4_noerr", 8'(err_o), 8'h0);
    end
    chk("t4_sel", 8'(sel_o), 8'h2);
    step();
    settle();
    chk("t4_mreq_off", 8'(mem_req_o), 8'h0);
    chk("t4_err", 8'(err_o), 8'h1);
    chk("t4_errid", 8'(err_id_o), 8'h2);
    req_i = 4'b1111;
    step();
    settle();
    chk("t4_next_sel", 8'(sel_o), 8'h3);
    chk("t4_err_pulse", 8'(err_o), 8'h0);
    mem_ack_i = 1'b1;
    settle();
    chk("t4_next_ack", 8'(ack_o), 8'h8);
    step();
    mem_ack_i = 1'b0;
    req_i     = 4'b0000;
    settle();
    chk("t4_idle", 8'(gnt_o), 8'h0);

    // ack lands in the timeout cycle
    req_i = 4'b0100;
    for (int c = 0; c < 4; c++) step();
    mem_ack_i = 1'b1;
    settle();
    chk("t5_ack", 8'(ack_o), 8'h4);
    step();
    mem_ack_i = 1'b0;
    req_i     = 4'b0000;
    settle();
    chk("t5_noerr", 8'(err_o), 8'h0);
    chk("t5_idle", 8'(gnt_o), 8'h0);

    // reset mid-transaction, memory ack during idle ignored
    req_i = 4'b0010;
    step();
    settle();
    chk("t6_gnt", 8'(gnt_o), 8'h2);
    rst_i = 1'b1;
    step();
    mem_ack_i = 1'b1;
    settle();
    chk("t6_gnt0", 8'(gnt_o), 8'h0);
    chk("t6_sel0", 8'(sel_o), 8'h0);
    chk("t6_mreq0", 8'(mem_req_o), 8'h0);
    chk("t6_ack0", 8'(ack_o), 8'h0);
    chk("t6_err0", 8'(err_o), 8'h0);
    chk("t6_errid0", 8'(err_id_o), 8'h0);
    rst_i     = 1'b0;
    mem_ack_i = 1'b0;
    req_i     = 4'b1010;
    step();
    settle();
    chk("t6_regrant_sel", 8'(sel_o), 8'h1);
    chk("t6_regrant_gnt", 8'(gnt_o), 8'h2);
    chk("t6_regrant_err", 8'(err_o), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
